// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: access size encoding (same as the
// core's load/store size), arbiter state and access owner.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    SIZE_NONE = 2'd0,
    SIZE_BYTE = 2'd1,
    SIZE_HALF = 2'd2,
    SIZE_WORD = 2'd3
  } size_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  // A write of size NONE is accepted but never reaches the memory.
  function automatic logic is_null_write(input logic wen, input logic [1:0] size);
    return wen && (size == SIZE_NONE);
  endfunction

endpackage

// File: rtl/mem_lat_timer.sv
// Loadable down-counter that times one memory access. 'expire' is high in
// the last cycle of the access (count == 1); the counter parks at zero.
module mem_lat_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] count_d, count_q;

  // Next count: reload on a new access, otherwise count down to zero.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the instruction-fetch and data ports onto one single-port
// synchronous memory with MEM_LAT cycles of read latency. One access at a
// time; data beats fetch. Build option ARB_FAIRNESS_EN lets a waiting fetch
// win after MAX_D_RUN consecutive data grants.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_LAT   = 1,
  parameter int MAX_D_RUN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_wen,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  localparam int  TMR_W     = $clog2(MEM_LAT + 1);
  // A misconfigured instance never grants rather than misbehaving silently.
  localparam bit  PARAMS_OK = (MEM_LAT >= 1) && (MAX_D_RUN >= 1);

  state_e              state_d, state_q;
  owner_e              owner_d, owner_q;
  logic                mem_en_d, mem_en_q;
  logic                mem_wen_d, mem_wen_q;
  logic [1:0]          mem_size_d, mem_size_q;
  logic [ADDR_W-1:0]   mem_addr_d, mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_d, mem_wdata_q;
  logic                if_rvalid_d, if_rvalid_q;
  logic                d_rvalid_d, d_rvalid_q;
  logic [DATA_W-1:0]   if_rdata_d, if_rdata_q;
  logic [DATA_W-1:0]   d_rdata_d, d_rdata_q;

  logic                tmr_load;
  logic [TMR_W-1:0]    tmr_value;
  logic                tmr_expire;

  logic                arb_idle;
  logic                if_first;
  logic                grant_d;
  logic                grant_if;

  // Grants are only given while idle and out of reset.
  assign arb_idle = PARAMS_OK && rst_n && (state_q == IDLE);

`ifdef ARB_FAIRNESS_EN
  localparam int FAIR_W = $clog2(MAX_D_RUN + 1);

  logic [FAIR_W-1:0] fair_cnt_d, fair_cnt_q;

  assign if_first = if_req && d_req && (fair_cnt_q == FAIR_W'(MAX_D_RUN));

  // Count data grants taken while fetch waits; any gap in fetch demand or a
  // fetch grant restarts the run.
  always_comb begin
    fair_cnt_d = fair_cnt_q;
    if (grant_if || !if_req) begin
      fair_cnt_d = '0;
    end else if (grant_d) begin
      fair_cnt_d = fair_cnt_q + 1'b1;
    end
  end

  // Fairness run counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fair_cnt_q <= '0;
    end else begin
      fair_cnt_q <= fair_cnt_d;
    end
  end
`else
  assign if_first = 1'b0;
`endif

  assign grant_d  = arb_idle && d_req && !if_first;
  assign grant_if = arb_idle && if_req && !grant_d;

  // Next-state, memory command and response logic.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_en_d    = 1'b0;
    mem_wen_d   = mem_wen_q;
    mem_size_d  = mem_size_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    tmr_load    = 1'b0;
    tmr_value   = '0;

    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d     = BUSY;
          owner_d     = OWN_D;
          mem_en_d    = !is_null_write(d_wen, d_size);
          mem_wen_d   = d_wen;
          mem_size_d  = d_size;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          tmr_load    = 1'b1;
          tmr_value   = d_wen ? TMR_W'(1) : TMR_W'(MEM_LAT);
        end else if (grant_if) begin
          state_d     = BUSY;
          owner_d     = OWN_IF;
          mem_en_d    = 1'b1;
          mem_wen_d   = 1'b0;
          mem_size_d  = SIZE_WORD;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          tmr_load    = 1'b1;
          tmr_value   = TMR_W'(MEM_LAT);
        end
      end
      BUSY: begin
        if (tmr_expire) begin
          state_d = IDLE;
          if (!mem_wen_q) begin
            if (owner_q == OWN_IF) begin
              if_rvalid_d = 1'b1;
              if_rdata_d  = mem_rdata;
            end else begin
              d_rvalid_d = 1'b1;
              d_rdata_d  = mem_rdata;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state, held memory command and port responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      mem_en_q    <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_size_q  <= SIZE_NONE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_en_q    <= mem_en_d;
      mem_wen_q   <= mem_wen_d;
      mem_size_q  <= mem_size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  mem_lat_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .value (tmr_value),
    .expire(tmr_expire)
  );

  assign if_gnt    = grant_if;
  assign d_gnt     = grant_d;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_wen   = mem_wen_q;
  assign mem_size  = mem_size_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign stall     = (if_req && !grant_if) || (d_req && !grant_d);

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the core's instruction-fetch port and data port onto one single-port synchronous memory with fixed read latency. Sits between `cpu` and the unified memory model. Accepts one access at a time, returns read data with a one-cycle valid pulse, and drives a `stall` output so the pipeline can freeze its fetch or memory stage while a request waits.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `MEM_LAT`, 1, cycles from memory issue to valid `mem_rdata`; must be ≥1.
- `MAX_D_RUN`, 4, consecutive data grants allowed while fetch waits (fairness build only); must be ≥1.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `if_req` in 1; `if_addr` in ADDR_W: fetch request.
- `if_gnt` out 1; `if_rvalid` out 1; `if_rdata` out DATA_W: fetch grant and response.
- `d_req` in 1; `d_wen` in 1; `d_size` in 2; `d_addr` in ADDR_W; `d_wdata` in DATA_W: data request.
- `d_gnt` out 1; `d_rvalid` out 1; `d_rdata` out DATA_W: data grant and read response.
- `mem_en` out 1; `mem_wen` out 1; `mem_size` out 2; `mem_addr` out ADDR_W; `mem_wdata` out DATA_W: memory command.
- `mem_rdata` in DATA_W: memory read data.
- `stall` out 1: a request is pending and not granted this cycle.

## Operation
- **States:**
  - `IDLE`: arbitration is combinational; at most one `*_gnt` is high.
  - `BUSY`: an access is in flight; both grants are 0.
- **Grant priority:** data beats fetch, because data belongs to the older instruction. The fairness override is described under Configuration.
- **On grant:**
  - Register the winner's address, write data, wen and size into the `mem_*` outputs.
  - Record the owner (IF or D).
  - Load the latency timer with MEM_LAT for a read, or 1 for a write.
  - Enter `BUSY`.
- **Fetch:** always a word read; `mem_size` = 3 and `mem_wen` = 0.
- **Command hold:** `mem_en` is a one-cycle pulse. `mem_addr`, `mem_wdata`, `mem_wen` and `mem_size` hold their values until the next grant.
- **Read completion:** when the timer expires, capture `mem_rdata` into the owner's `*_rdata`. Pulse the owner's `*_rvalid` for one cycle and return to `IDLE` in that same cycle.
- **`*_rdata` hold:** holds its value until the next read by that port completes.
- **Writes:** no `rvalid`; the state returns to `IDLE` one cycle after `mem_en`.
- **Null write:** `d_wen`=1 with `d_size`=0 is granted, but `mem_en` stays 0 and the state returns to `IDLE` after one cycle.
- **Requester rules:**
  - Hold `req` and its payload stable until `gnt`.
  - Dropping `req` before `gnt` is a legal withdrawal with no side effect.
  - `req` still high in the cycle after `gnt` is a new request.
- **`stall`:** `(if_req & ~if_gnt) | (d_req & ~d_gnt)`, combinational.
- **Reset values:** every output and register is 0, the state is `IDLE`, and the fairness counter is 0.
- **Reset mid-access:** the in-flight access is abandoned and no `rvalid` is produced. The memory may still complete a write that was already issued.

## Timing
- Grant in cycle N → `mem_en` high in N+1.
- `mem_rdata` is sampled at the end of cycle N+MEM_LAT → `*_rvalid` high in N+MEM_LAT+1.
- A new grant is possible in the same cycle as `*_rvalid`.
- Read occupancy is MEM_LAT+1 cycles. Throughput is one read per MEM_LAT+1 cycles.
- Write: grant in N, `mem_en` in N+1, `IDLE` in N+2.
- `stall` stays 1 for the entire time a request waits through `BUSY`.

## Configuration
- `ARB_FAIRNESS_EN` defined:
  - A counter increments on each data grant made while `if_req` is high.
  - It clears on a fetch grant or when `if_req` is low.
  - When it equals MAX_D_RUN and both requests are pending, fetch wins.
- Undefined: strict data priority; fetch can starve.

## Structure
- **Package `mem_arb_pkg`:**
  - Size encoding `SIZE_NONE`=0, `SIZE_BYTE`=1, `SIZE_HALF`=2, `SIZE_WORD`=3 (same encoding as the core's store/load size).
  - State enum `IDLE`/`BUSY`.
  - Owner encoding `OWN_IF`/`OWN_D`.
- **Sub-module `mem_lat_timer`:** loadable down-counter with `load`, `value` and `expire` signals.

## Test plan
- Fetch-only read, MEM_LAT=1, `if_addr`=0x10, memory returns 0x00500093 → `if_gnt` in N, `mem_en` in N+1, `if_rvalid` with 0x00500093 in N+2.
- Simultaneous `if_req`/`d_req` read at 0x40, fairness off → `d_gnt` first; `if_gnt` in the cycle `d_rvalid` pulses; `stall`=1 throughout the wait.
- Store byte, `d_size`=1, `d_addr`=0x80, `d_wdata`=0xAB → `mem_wen`=1, `mem_size`=1 in N+1; no `d_rvalid`; `IDLE` in N+2.
- MEM_LAT=3, data read → `d_rvalid` exactly 4 cycles after grant; fetch request held during the access is not granted early.
- With `ARB_FAIRNESS_EN`, MAX_D_RUN=2, continuous `d_req` and `if_req` → grant order D, D, IF, D, D, IF.
- `rst_n` pulsed low during `BUSY` of a read → all outputs 0 immediately; no `rvalid` after release; the next request is granted normally.
